data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (range 1..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state on posedge CLK.
REQ-004 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1 = store), req_addr in BIN_DIG (byte address), req_wdata in BIN_DIG, req_funct3 in 3 (RV32I load/store funct3).
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out BIN_DIG, rsp_err out 1 (misaligned access).

Function
REQ-007 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one request outstanding at most.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, and address, data, we and funct3 are captured at that edge.
REQ-009 SHALL, on acceptance, load a 4-bit counter with LATENCY-1, enter BUSY, and decrement the counter each cycle in BUSY.
REQ-010 SHALL perform the access on the BUSY edge where the counter is 0, enter RESP and assert rsp_valid, which is therefore first high exactly LATENCY cycles after the acceptance edge.
REQ-011 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge; req_ready is not high in the same cycle as that handshake.
REQ-012 SHALL index memory with req_addr[2+:log2(DEPTH_WORDS)]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-013 SHALL for loads: LB/LH sign-extend, LBU/LHU zero-extend the byte or half selected by addr[1:0]; LW returns the full word.
REQ-014 SHALL for stores: SB/SH/SW write only the addressed byte lanes, with data taken from the low bits of req_wdata; rsp_rdata=0 for stores.
REQ-015 SHALL treat reserved funct3 values (011, 110, 111) as LW for loads and as no-write for stores, with rsp_err=1.
REQ-016 SHALL NOT alter memory contents on reset; contents are undefined at power-up.

Reset
REQ-017 SHALL, while RST=1, force the state to IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready becomes 1 in the first cycle after RST deasserts.
REQ-018 SHALL abort an in-flight request when RST asserts in BUSY or RESP: no write and no response.

Configuration
REQ-019 SHALL, with DMEM_MISALIGN_CHECK_EN defined, respond to half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 with rsp_err=1, rsp_rdata=0 and no memory write, after the same latency.
REQ-020 SHALL, without DMEM_MISALIGN_CHECK_EN, force the offending low address bits to 0 (natural alignment) and set rsp_err=0 for such accesses.

Structure
REQ-021 SHALL place funct3 constants (F3_LB..F3_SW), the FSM state enum and BIN_DIG in package defs.
REQ-022 SHALL put lane selection and extension in the combinational sub-module data_mem_align, which produces the byte-enable mask, the shifted write data and the extended read data.

Verification
REQ-023 SHALL cover: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid rises 2 cycles after each acceptance.
REQ-024 SHALL cover: after REQ-023, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-025 SHALL cover: SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; LW 0x10+DEPTH_WORDS*4 -> the same value (wrap).
REQ-026 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-027 SHALL cover: LH 0x11 -> with the macro, rsp_err=1 and rsp_rdata=0; without the macro, the response equals LH 0x10 and rsp_err=0.
REQ-028 SHALL cover: SW 0x12345678 to 0x20 accepted, then RST pulsed during BUSY -> rsp_valid never rises, and a later LW 0x20 returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data memory responder.
// Package name is fixed as defs; the bus width BIN_DIG lives here.
package defs;

  localparam int unsigned BIN_DIG = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store master and the data memory responder.
interface data_mem_responder_if
  import defs::*;
();
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [BIN_DIG-1:0] req_addr;
  logic [BIN_DIG-1:0] req_wdata;
  logic [2:0]         req_funct3;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BIN_DIG-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_align.sv
// Byte-lane selection, store data shifting and load extension for RV32I funct3.
// Optional DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module data_mem_align
  import defs::*;
(
  input  logic [2:0]         funct3_i,
  input  logic               we_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [BIN_DIG-1:0] wdata_i,
  input  logic [BIN_DIG-1:0] rword_i,
  output logic [3:0]         be_o,
  output logic [BIN_DIG-1:0] wdata_o,
  output logic [BIN_DIG-1:0] rdata_o,
  output logic               err_o
);
  logic [1:0]         size;  // 0 byte, 1 half, 2 word
  logic               sign;
  logic               reserved;
  logic               kill;
  logic [1:0]         off;
  logic [3:0]         mask;
  logic [BIN_DIG-1:0] rsh;

  always_comb begin
    size     = 2'd2;
    sign     = 1'b0;
    reserved = 1'b0;
    unique case (funct3_i)
      F3_LB:   begin size = 2'd0; sign = 1'b1; end
      F3_LH:   begin size = 2'd1; sign = 1'b1; end
      F3_LW:   size = 2'd2;
      F3_LBU:  size = 2'd0;
      F3_LHU:  size = 2'd1;
      default: reserved = 1'b1;
    endcase

    // Offending low bits are dropped so every access is naturally aligned.
    unique case (size)
      2'd0:    begin off = addr_lo_i;            mask = 4'b0001; end
      2'd1:    begin off = {addr_lo_i[1], 1'b0}; mask = 4'b0011; end
      default: begin off = 2'b00;                mask = 4'b1111; end
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    kill = ((size == 2'd1) && addr_lo_i[0]) || ((size == 2'd2) && (addr_lo_i != 2'b00));
`else
    kill = 1'b0;
`endif

    rsh     = rword_i >> {off, 3'b000};
    wdata_o = wdata_i << {off, 3'b000};
    be_o    = (we_i && !reserved && !kill) ? (mask << off) : 4'b0000;
    err_o   = reserved | kill;

    if (we_i || kill) begin
      rdata_o = '0;
    end else begin
      unique case (size)
        2'd0:    rdata_o = {{24{sign & rsh[7]}}, rsh[7:0]};
        2'd1:    rdata_o = {{16{sign & rsh[15]}}, rsh[15:0]};
        default: rdata_o = rsh;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with fixed LATENCY from acceptance to response.
// Build with DMEM_MISALIGN_CHECK_EN to report misaligned half/word accesses as errors.
module data_mem_responder
  import defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic                 CLK,
  input logic                 RST,
  data_mem_responder_if.slave bus_if
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [AW+1:0]      addr_q;
  logic [BIN_DIG-1:0] wdata_q;
  logic [BIN_DIG-1:0] rdata_q;
  logic               err_q;
  logic [BIN_DIG-1:0] mem_q [DEPTH_WORDS];

  logic               accept;
  logic               access;
  logic [3:0]         be;
  logic [BIN_DIG-1:0] wsh;
  logic [BIN_DIG-1:0] rext;
  logic               err;
  logic               unused_addr;

  assign unused_addr = ^bus_if.req_addr[BIN_DIG-1:AW+2];

  assign bus_if.req_ready = (state_q == StIdle) && !RST;
  assign bus_if.rsp_valid = (state_q == StResp);
  assign bus_if.rsp_rdata = rdata_q;
  assign bus_if.rsp_err   = err_q;
  assign accept           = bus_if.req_valid && bus_if.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus_if.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  data_mem_align u_align (
    .funct3_i  (f3_q),
    .we_i      (we_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (mem_q[addr_q[AW+1:2]]),
    .be_o      (be),
    .wdata_o   (wsh),
    .rdata_o   (rext),
    .err_o     (err)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus_if.req_we;
        f3_q    <= bus_if.req_funct3;
        addr_q  <= bus_if.req_addr[AW+1:0];
        wdata_q <= bus_if.req_wdata;
      end
      if (access) begin
        rdata_q <= rext;
        err_q   <= err;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (access) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LAT     = 2;
  localparam int unsigned BYTES   = DEPTH * 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mb [BYTES];

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus_if (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the load/store rules on a byte array.
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int unsigned sz, b;
    bit sgn, rsv;
    logic [31:0] v;
    sgn = 0;
    rsv = 0;
    case (f3)
      3'd0:    begin sz = 1; sgn = 1; end
      3'd1:    begin sz = 2; sgn = 1; end
      3'd2:    sz = 4;
      3'd4:    sz = 1;
      3'd5:    sz = 2;
      default: begin sz = 4; rsv = 1; end
    endcase
    b  = a % BYTES;
    rd = 0;
    er = rsv;
    if (b % sz != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      er = 1;
      return;
`else
      b = b - b % sz;
`endif
    end
    if (we) begin
      if (!rsv) for (int i = 0; i < int'(sz); i++) mb[b+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mb[b+i];
      if (sgn && v[8*sz-1]) for (int i = int'(sz); i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  task automatic run(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input int hold, output logic [31:0] rd);
    int n;
    int lat;
    logic [31:0] exp_rd;
    logic exp_er;
    logic er;
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    bus.rsp_ready  = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    model(we, a, wd, f3, exp_rd, exp_er);
    check("rsp_rdata", rd, exp_rd);
    check("rsp_err", 32'(er), 32'(exp_er));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, exp_rd);
      check("hold_err", 32'(bus.rsp_err), 32'(exp_er));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] prior;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          we;
    bit          saw;
    int          n;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.rsp_ready  = 1'b1;

    repeat (3) @(negedge CLK);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    RST = 1'b0;
    #1;
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);

    // Give the first 256 bytes defined contents.
    for (int i = 0; i < 64; i++) run(1'b1, 32'(i * 4), $urandom, 3'b010, 0, rd);

    run(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd);
    check("sw_rdata_zero", rd, 32'h0);
    run(1'b0, 32'h10, 32'h0, 3'b010, 0, rd);
    check("lw_10", rd, 32'hDEADBEEF);
    run(1'b0, 32'h13, 32'h0, 3'b000, 0, rd);
    check("lb_13", rd, 32'hFFFFFFDE);
    run(1'b0, 32'h13, 32'h0, 3'b100, 0, rd);
    check("lbu_13", rd, 32'h000000DE);
    run(1'b0, 32'h12, 32'h0, 3'b001, 0, rd);
    check("lh_12", rd, 32'hFFFFDEAD);
    run(1'b0, 32'h10, 32'h0, 3'b101, 0, rd);
    check("lhu_10", rd, 32'h0000BEEF);
    run(1'b1, 32'h11, 32'h00000055, 3'b000, 0, rd);
    run(1'b0, 32'h10, 32'h0, 3'b010, 0, rd);
    check("lw_after_sb", rd, 32'hDEAD55EF);
    run(1'b0, 32'h10 + BYTES, 32'h0, 3'b010, 0, rd);
    check("lw_wrap", rd, 32'hDEAD55EF);
    run(1'b0, 32'h10, 32'h0, 3'b010, 5, rd);
    check("lw_hold", rd, 32'hDEAD55EF);
    run(1'b0, 32'h11, 32'h0, 3'b001, 0, rd);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("lh_11_misal", rd, 32'h0);
    check("lh_11_err", 32'(bus.rsp_err), 32'd1);
`else
    check("lh_11_aligned", rd, 32'h000055EF);
`endif
    run(1'b0, 32'h10, 32'h0, 3'b011, 0, rd);
    check("reserved_load", rd, 32'hDEAD55EF);

    // Abort a store in BUSY with a reset pulse.
    run(1'b0, 32'h20, 32'h0, 3'b010, 0, prior);
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    bus.req_funct3 = 3'b010;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_rel_ready", 32'(bus.req_ready), 32'd1);
    saw = 0;
    repeat (6) begin
      @(posedge CLK);
      #1;
      saw |= bus.rsp_valid;
    end
    check("abort_no_rsp", 32'(saw), 32'd0);
    run(1'b0, 32'h20, 32'h0, 3'b010, 0, rd);
    check("abort_no_write", rd, prior);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = (32'($urandom_range(0, 255))) | ($urandom << 12);
      if (we) begin
        case ($urandom_range(0, 7))
          0, 1:    f3 = 3'b000;
          2, 3:    f3 = 3'b001;
          4, 5:    f3 = 3'b010;
          6:       f3 = 3'b011;
          default: f3 = 3'b111;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      run(we, a, $urandom, f3, (i % 17 == 0) ? 2 : 0, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
